fc_argmax_classifier: RTL and testbench



---
 rtl/fc_argmax_classifier_if.sv | 29 ++
 rtl/fc_argmax_classifier.sv | 125 ++++++++++++
 tb/tb_fc_argmax_classifier.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_argmax_classifier_if.sv
// Logit-in / result-out bundle for the argmax classifier.
// master = upstream/consumer side, slave = classifier. Macro CLASSIFIER_MARGIN_EN adds margin.
interface fc_argmax_classifier_if #(
   parameter int N_CLASS = 10,
   parameter int DATA_W  = 16,
   parameter int IDX_W   = 4
);
   logic [N_CLASS:1][DATA_W-1:0] in_feature;
   logic                         capture;
   logic                         result_ready;
   logic [IDX_W-1:0]             class_id;
   logic signed [DATA_W-1:0]     max_value;
   logic                         result_valid;
   logic                         busy;
   logic                         overrun;
`ifdef CLASSIFIER_MARGIN_EN
   logic [DATA_W-1:0]            margin;

   modport master (output in_feature, capture, result_ready,
                   input  class_id, max_value, result_valid, busy, overrun, margin);
   modport slave  (input  in_feature, capture, result_ready,
                   output class_id, max_value, result_valid, busy, overrun, margin);
`else
   modport master (output in_feature, capture, result_ready,
                   input  class_id, max_value, result_valid, busy, overrun);
   modport slave  (input  in_feature, capture, result_ready,
                   output class_id, max_value, result_valid, busy, overrun);
`endif
endinterface

// File: rtl/fc_argmax_classifier.sv
// Captures N_CLASS logits, scans them one per cycle and holds the argmax under valid/ready.
// Optional CLASSIFIER_MARGIN_EN tracks the runner-up and reports best minus second-best.
module fc_argmax_classifier #(
   parameter int N_CLASS = 10,
   parameter int DATA_W  = 16,
   parameter int IDX_W   = 4
) (
   input logic                 clk,
   input logic                 n_reset,
   fc_argmax_classifier_if.slave bus
);
   // Scan index must reach N_CLASS itself, which can need one more bit than class_id.
   localparam int AW = $clog2(N_CLASS + 1);

   typedef logic signed [DATA_W-1:0] data_t;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                        state;
   logic [N_CLASS:1][DATA_W-1:0]  buf_q;
   logic [AW-1:0]                 idx_q;
   logic [AW-1:0]                 best_idx;
   data_t                         best_val;
   data_t                         cur_val;
   data_t                         nxt_val;
   logic [AW-1:0]                 nxt_idx;
   logic                          gt;
   logic                          take;
   logic                          last;

   logic [IDX_W-1:0]              class_q;
   data_t                         max_q;
   logic                          valid_q;
   logic                          busy_q;
   logic                          overrun_q;

   assign cur_val = data_t'(buf_q[idx_q]);
   assign gt      = cur_val > best_val;
   assign nxt_val = gt ? cur_val : best_val;
   assign nxt_idx = gt ? idx_q : best_idx;
   assign take    = bus.capture && (state != SCAN);
   assign last    = (idx_q == AW'(N_CLASS));

`ifdef CLASSIFIER_MARGIN_EN
   data_t             second_val;
   data_t             nxt_second;
   logic [DATA_W-1:0] margin_q;

   assign nxt_second = gt ? best_val : ((cur_val > second_val) ? cur_val : second_val);

   // best >= second always, so the true difference fits DATA_W unsigned and the
   // wrapped DATA_W-bit subtraction is exact.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         second_val <= '0;
         margin_q   <= '0;
      end else if (take) begin
         second_val <= data_t'({1'b1, {(DATA_W-1){1'b0}}});
      end else if (state == SCAN) begin
         second_val <= nxt_second;
         if (last) margin_q <= DATA_W'(nxt_val - nxt_second);
      end
   end

   assign bus.margin = margin_q;
`endif

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state     <= IDLE;
         buf_q     <= '0;
         idx_q     <= '0;
         best_idx  <= '0;
         best_val  <= '0;
         class_q   <= '0;
         max_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (state == SCAN && bus.capture) overrun_q <= 1'b1;
         case (state)
            IDLE, DONE: begin
               if (take) begin
                  // Old result in DONE is dropped; capture beats result_ready.
                  buf_q    <= bus.in_feature;
                  best_val <= data_t'(bus.in_feature[1]);
                  best_idx <= AW'(1);
                  idx_q    <= AW'(2);
                  state    <= SCAN;
                  busy_q   <= 1'b1;
                  valid_q  <= 1'b0;
               end else if (state == DONE && bus.result_ready) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            SCAN: begin
               best_val <= nxt_val;
               best_idx <= nxt_idx;
               if (last) begin
                  state   <= DONE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
                  class_q <= IDX_W'(nxt_idx - AW'(1));
                  max_q   <= nxt_val;
               end else begin
                  idx_q <= idx_q + AW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.class_id     = class_q;
   assign bus.max_value    = max_q;
   assign bus.result_valid = valid_q;
   assign bus.busy         = busy_q;
   assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed bench for fc_argmax_classifier: cycle model of argmax/handshake plus literal spot checks.
module tb_fc_argmax_classifier;
   localparam int N  = 10;
   localparam int W  = 16;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk = ~clk;

   fc_argmax_classifier_if #(.N_CLASS(N), .DATA_W(W), .IDX_W(IW)) bus ();

   fc_argmax_classifier #(.N_CLASS(N), .DATA_W(W), .IDX_W(IW)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus.slave)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;
   int lg [1:N];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain max / first-max-index / top-two difference over the captured logits.
   function automatic int f_max(input logic [N:1][W-1:0] v);
      int m, x;
      m = $signed(v[1]);
      for (int i = 2; i <= N; i++) begin
         x = $signed(v[i]);
         if (x > m) m = x;
      end
      return m;
   endfunction

   function automatic int f_cls(input logic [N:1][W-1:0] v);
      int m, x;
      m = f_max(v);
      for (int i = 1; i <= N; i++) begin
         x = $signed(v[i]);
         if (x == m) return i - 1;
      end
      return -1;
   endfunction

   function automatic int f_mrg(input logic [N:1][W-1:0] v);
      int m, skip, s, x;
      bit have;
      m    = f_max(v);
      skip = f_cls(v) + 1;
      s    = 0;
      have = 1'b0;
      for (int i = 1; i <= N; i++) begin
         x = $signed(v[i]);
         if (i != skip && (!have || x > s)) begin
            s    = x;
            have = 1'b1;
         end
      end
      return m - s;
   endfunction

   bit m_busy, m_valid, m_overrun;
   int m_cnt, m_cls, m_max, m_mrg, p_cls, p_max, p_mrg;

   always @(posedge clk) begin
      if (!n_reset) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_overrun <= 1'b0;
         m_cnt <= 0; m_cls <= 0; m_max <= 0; m_mrg <= 0;
      end else if (m_busy) begin
         if (bus.capture) m_overrun <= 1'b1;
         if (m_cnt == 1) begin
            m_busy <= 1'b0; m_valid <= 1'b1;
            m_cls <= p_cls; m_max <= p_max; m_mrg <= p_mrg;
         end
         m_cnt <= m_cnt - 1;
      end else if (bus.capture) begin
         m_busy <= 1'b1; m_valid <= 1'b0; m_cnt <= N - 1;
         p_cls <= f_cls(bus.in_feature);
         p_max <= f_max(bus.in_feature);
         p_mrg <= f_mrg(bus.in_feature);
      end else if (m_valid && bus.result_ready) begin
         m_valid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", int'(bus.busy), int'(m_busy));
         chk("result_valid", int'(bus.result_valid), int'(m_valid));
         chk("overrun", int'(bus.overrun), int'(m_overrun));
         if (m_valid) begin
            chk("class_id", int'(bus.class_id), m_cls);
            chk("max_value", int'(bus.max_value), m_max);
`ifdef CLASSIFIER_MARGIN_EN
            chk("margin", int'(bus.margin), m_mrg);
`endif
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_cap(input bit with_ready);
      for (int i = 1; i <= N; i++) bus.in_feature[i] = W'(lg[i]);
      bus.capture      = 1'b1;
      bus.result_ready = with_ready;
      tick(1);
      bus.capture      = 1'b0;
      bus.result_ready = 1'b0;
      for (int i = 1; i <= N; i++) bus.in_feature[i] = W'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.result_valid && n < 40) begin
         tick(1);
         n++;
      end
      if (!bus.result_valid) chk("valid_timeout", 0, 1);
   endtask

   task automatic accept();
      bus.result_ready = 1'b1;
      tick(1);
      bus.result_ready = 1'b0;
   endtask

   task automatic check_lit(input string tag, input int cls, input int mx, input int mrg);
      chk({tag, "_class"}, int'(bus.class_id), cls);
      chk({tag, "_max"}, int'(bus.max_value), mx);
`ifdef CLASSIFIER_MARGIN_EN
      chk({tag, "_margin"}, int'(bus.margin), mrg);
`else
      if (mrg < 0) chk({tag, "_margin_arg"}, mrg, 0);
`endif
   endtask

   initial begin
      int n, cnt;
      bus.capture      = 1'b0;
      bus.result_ready = 1'b0;
      bus.in_feature   = '0;
      n_reset          = 1'b0;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      check_lit("reset", 0, 0, 0);
      chk("reset_valid", int'(bus.result_valid), 0);
      chk("reset_busy", int'(bus.busy), 0);
      n_reset = 1'b1;
      tick(1);

      // Tie on 100 at classes 2 and 4: lowest index wins.
      lg = '{5, -3, 100, 7, 100, 0, -8, 2, 99, 1};
      drive_cap(1'b0);
      wait_valid(n);
      chk("latency", n, 9);
      check_lit("tie", 2, 100, 0);
      tick(20);
      chk("hold_valid", int'(bus.result_valid), 1);
      check_lit("hold", 2, 100, 0);
      accept();
      chk("accept_valid", int'(bus.result_valid), 0);
      chk("accept_busy", int'(bus.busy), 0);
      tick(2);

      for (int i = 1; i <= N; i++) lg[i] = -32768;
      drive_cap(1'b0);
      wait_valid(n);
      check_lit("allmin", 0, -32768, 0);
      accept();

      lg[N] = 32767;
      drive_cap(1'b0);
      wait_valid(n);
      check_lit("extreme", 9, 32767, 65535);
      accept();
      tick(1);

      // Second capture four cycles into the scan must be ignored.
      lg = '{5, -3, 100, 7, 100, 0, -8, 2, 99, 1};
      drive_cap(1'b0);
      tick(3);
      lg = '{50, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      drive_cap(1'b0);
      wait_valid(n);
      check_lit("overrun", 2, 100, 0);
      chk("overrun_set", int'(bus.overrun), 1);
      accept();
      tick(5);
      chk("overrun_sticky", int'(bus.overrun), 1);
      n_reset = 1'b0;
      tick(1);
      chk("overrun_cleared", int'(bus.overrun), 0);
      n_reset = 1'b1;
      tick(1);

      // Capture together with ready in DONE: recapture wins.
      lg = '{5, -3, 100, 7, 100, 0, -8, 2, 99, 1};
      drive_cap(1'b0);
      wait_valid(n);
      lg = '{1, 2, 3, 4, 5, 6, 500, 8, 9, 10};
      drive_cap(1'b1);
      chk("recap_valid", int'(bus.result_valid), 0);
      chk("recap_busy", int'(bus.busy), 1);
      wait_valid(n);
      chk("recap_latency", n, 9);
      check_lit("recap", 6, 500, 490);
      accept();
      tick(1);

      // Reset at scan cycle 5 abandons the scan.
      lg = '{5, -3, 100, 7, 100, 0, -8, 2, 99, 1};
      drive_cap(1'b0);
      tick(4);
      n_reset = 1'b0;
      tick(1);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_valid", int'(bus.result_valid), 0);
      check_lit("midrst", 0, 0, 0);
      n_reset = 1'b1;
      cnt = 0;
      repeat (15) begin
         tick(1);
         if (bus.result_valid) cnt++;
      end
      chk("midrst_no_valid", cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
